adder_sub_arbiter: RTL and testbench

Shares one 8-bit `adder_sub` between two requesters and sequences wide (8×BYTES-bit) add/subtract operations through it byte by byte, LSB first, chaining carry. Sits between the requesting blocks and the shared `adder_sub` instance: it owns every `adder_sub` input and reads back `data_out`, `carry_out` and `out_en`. Arbitration is round-robin. Each operation is returned on a single shared response port.

---
 rtl/adder_sub_arbiter.sv | 165 ++++++++++++++++
 tb/tb_adder_sub_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_sub_arbiter.sv
// ---------------------------------------------------------------------------
// adder_sub_arbiter
//
// Shares one external 8-bit adder_sub between two requesters. A wide
// (8*BYTES-bit) add or subtract is run through the adder one byte at a time,
// LSB first, with the carry chained between bytes. Subtraction is done in add
// mode: B is inverted when the operation is accepted and the initial carry is 1.
// Requesters are served round-robin, and results come back on a single
// response port.
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   req{0,1}_valid/ready         request handshake (ready is combinational)
//   req{0,1}_a/_b/_sub           operands and op select (1 = A-B)
//   rsp_valid/ready              response handshake
//   rsp_id, rsp_result, rsp_carry  owner, W-bit result, final carry (1 = no borrow)
//   add_a/_b/_add_en/_sub_en/_carry_in   drive the shared adder_sub
//   add_data_out/_carry_out/_out_en      read back from the shared adder_sub
// ---------------------------------------------------------------------------
module adder_sub_arbiter #(
  parameter  int BYTES = 4,
  localparam int W     = 8 * BYTES
) (
  input  logic         clk,
  input  logic         reset_n,

  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_sub,

  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_sub,

  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic         rsp_carry,

  output logic [7:0]   add_a,
  output logic [7:0]   add_b,
  output logic         add_add_en,
  output logic         add_sub_en,
  output logic         add_carry_in,
  input  logic [7:0]   add_data_out,
  input  logic         add_carry_out,
  input  logic         add_out_en
);

  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, b_q;        // b_q already holds ~B for subtraction
  logic [W-1:0]     result_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic             id_q;
  logic             last_q;          // requester served most recently

  logic             grant;
  logic             accept;
  logic             byte_done;
  logic             last_byte;
  logic             sel_sub;

  // Arbitration: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    if (req0_valid && req1_valid) grant = ~last_q;
    else                          grant = req1_valid;
  end

  // Gating with reset_n keeps both readies low while reset is held.
  assign accept     = reset_n && (state_q == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept &&  grant;
  assign sel_sub    = grant ? req1_sub : req0_sub;

  assign byte_done  = (state_q == EXEC) && add_out_en;
  assign last_byte  = (idx_q == LAST_IDX);

  // State register.
  // NOTE: every clocked block uses non-blocking (<=) assignments so all
  // registers update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: a default is assigned first so no path leaves state_d unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept)                  state_d = EXEC;
      EXEC: if (byte_done && last_byte)  state_d = DONE;
      DONE: if (rsp_ready)               state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  // Output logic: adder is only driven during EXEC; a stall simply re-drives
  // the same byte because idx_q and carry_q hold.
  always_comb begin
    add_a        = '0;
    add_b        = '0;
    add_add_en   = 1'b0;
    add_carry_in = 1'b0;
    if (state_q == EXEC) begin
      add_a        = a_q[{idx_q, 3'b000} +: 8];
      add_b        = b_q[{idx_q, 3'b000} +: 8];
      add_add_en   = 1'b1;
      add_carry_in = carry_q;
    end
  end

  assign add_sub_en = 1'b0;
  assign rsp_valid  = (state_q == DONE);
  assign rsp_result = result_q;
  assign rsp_carry  = carry_q;
  assign rsp_id     = id_q;

  // Operand capture.
  // NOTE: operand registers carry no reset; they are always loaded at accept
  // before they are used, and the adder outputs are masked outside EXEC.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= grant ? req1_a : req0_a;
      b_q <= sel_sub ? ~(grant ? req1_b : req0_b) : (grant ? req1_b : req0_b);
    end
  end

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_q    <= '0;
      carry_q  <= 1'b0;
      id_q     <= 1'b0;
      result_q <= '0;
      last_q   <= 1'b1;
    end else begin
      if (accept) begin
        carry_q <= sel_sub;
        idx_q   <= '0;
        id_q    <= grant;
      end
      if (byte_done) begin
        result_q[{idx_q, 3'b000} +: 8] <= add_data_out;
        carry_q                        <= add_carry_out;
        if (!last_byte) idx_q <= idx_q + 1'b1;
      end
      // Round-robin pointer moves at response handoff, not at accept.
      if ((state_q == DONE) && rsp_ready) last_q <= id_q;
    end
  end

endmodule

// File: tb/tb_adder_sub_arbiter.sv
// ---------------------------------------------------------------------------
// tb_adder_sub_arbiter
//
// Self-checking bench for adder_sub_arbiter (BYTES = 4). The shared adder_sub
// is modelled combinationally here, with a stall control that holds out_en low.
// A table of single operations is run first, followed by hand-written sequences
// for round-robin fairness, adder stalls, and reset in the middle of an
// operation.
// ---------------------------------------------------------------------------
module tb_adder_sub_arbiter;

  localparam int BYTES = 4;
  localparam int W     = 8 * BYTES;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_sub = 1'b0, req1_sub = 1'b0;
  logic         rsp_valid, rsp_id, rsp_carry;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_result;
  logic [7:0]   add_a, add_b, add_data_out;
  logic         add_add_en, add_sub_en, add_carry_in, add_carry_out, add_out_en;
  logic         stall = 1'b0;
  logic [8:0]   sum9;

  always #5 clk = ~clk;

  adder_sub_arbiter #(.BYTES(BYTES)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry),
    .add_a(add_a), .add_b(add_b), .add_add_en(add_add_en),
    .add_sub_en(add_sub_en), .add_carry_in(add_carry_in),
    .add_data_out(add_data_out), .add_carry_out(add_carry_out),
    .add_out_en(add_out_en)
  );

  // Combinational model of the shared adder_sub (add mode only).
  assign sum9          = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_carry_in};
  assign add_data_out  = add_add_en ? sum9[7:0] : 8'h00;
  assign add_carry_out = add_add_en ? sum9[8]   : 1'b0;
  assign add_out_en    = add_add_en & ~stall;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle step; leaves us 1 time unit after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic wait_ready(input logic id);
    int n;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 30) begin
      step();
      n++;
    end
    check("accept_seen", id ? req1_ready : req0_ready, 1'b1);
  endtask

  // Called in the accept cycle T. Checks the first byte drive, the response
  // latency and contents, then an optional DONE hold with rsp_ready low.
  task automatic collect(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic [W-1:0] er, input logic ec, input logic eid,
                         input int hold);
    logic [W-1:0] bx;
    int lat;
    bx = sub ? ~b : b;
    rsp_ready = (hold == 0);
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      step();
      lat++;
      if (lat == 1) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("byte0_add_en", add_add_en, 1'b1);
        check("byte0_add_a", add_a, a[7:0]);
        check("byte0_add_b", add_b, bx[7:0]);
        check("byte0_carry_in", add_carry_in, sub);
      end
    end
    check("rsp_latency", lat, BYTES + 1);
    check("rsp_result", rsp_result, er);
    check("rsp_carry", rsp_carry, ec);
    check("rsp_id", rsp_id, eid);
    if (hold > 0) begin
      // A request arriving in DONE must wait.
      req0_valid = 1'b1;
      repeat (hold) begin
        step();
        check("hold_valid", rsp_valid, 1'b1);
        check("hold_result", rsp_result, er);
        check("hold_req0_ready", req0_ready, 1'b0);
      end
      req0_valid = 1'b0;
      rsp_ready  = 1'b1;
    end
    step();
    check("rsp_drop", rsp_valid, 1'b0);
  endtask

  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] er;
    logic         ec;
    int           hold;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    if (v.id) begin
      req1_a = v.a; req1_b = v.b; req1_sub = v.sub; req1_valid = 1'b1;
    end else begin
      req0_a = v.a; req0_b = v.b; req0_sub = v.sub; req0_valid = 1'b1;
    end
    #1;
    wait_ready(v.id);
    collect(v.a, v.b, v.sub, v.er, v.ec, v.id, v.hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 0};
    vecs[1] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 0};
    vecs[2] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 0};
    vecs[3] = '{1'b0, 32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b1, 3};
    vecs[4] = '{1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 0};
    vecs[5] = '{1'b1, 32'h0000_0010, 32'h0000_0010, 1'b1, 32'h0000_0000, 1'b1, 0};

    // Reset with both requests active.
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 32'h1; req1_a = 32'h2;
    reset_n = 1'b0;
    step();
    step();
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_result", rsp_result, '0);
    check("rst_rsp_carry", rsp_carry, 1'b0);
    check("rst_rsp_id", rsp_id, 1'b0);
    check("rst_add_bus", {add_a, add_b, add_add_en, add_sub_en, add_carry_in}, '0);
    check("rst_req0_ready", req0_ready, 1'b0);
    check("rst_req1_ready", req1_ready, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset_n = 1'b1;
    step();

    // Table of single operations.
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
      check("sub_en_low", add_sub_en, 1'b0);
    end

    // Round robin: both requesters valid continuously, starting from reset.
    begin
      logic id_seen[4];
      int   acc_cyc[4];
      int   n_acc, n_rsp, cyc;
      do_reset();
      rsp_ready = 1'b1;
      req0_a = 32'h1;  req0_b = 32'h1; req0_sub = 1'b0;   // 1 + 1  = 2
      req1_a = 32'hA;  req1_b = 32'h3; req1_sub = 1'b1;   // 10 - 3 = 7
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      n_acc = 0; n_rsp = 0; cyc = 0;
      while (n_rsp < 4 && cyc < 60) begin
        if (n_acc == 4) begin
          req0_valid = 1'b0; req1_valid = 1'b0;
        end
        if (req0_ready && req1_ready) check("rr_both_ready", 1'b1, 1'b0);
        if ((req0_ready || req1_ready) && n_acc < 4) begin
          id_seen[n_acc] = req1_ready;
          acc_cyc[n_acc] = cyc;
          n_acc++;
        end
        if (rsp_valid) begin
          check("rr_rsp_id", rsp_id, n_rsp[0]);
          check("rr_rsp_result", rsp_result, n_rsp[0] ? 32'h7 : 32'h2);
          n_rsp++;
        end
        step();
        cyc++;
      end
      check("rr_accepts", n_acc, 4);
      check("rr_responses", n_rsp, 4);
      for (int i = 0; i < 4; i++) begin
        if (i < n_acc) check("rr_id_seq", id_seen[i], i[0]);
        if (i > 0 && i < n_acc) check("rr_spacing", acc_cyc[i] - acc_cyc[i-1], BYTES + 2);
      end
      step();
    end

    // Stall: out_en low for 3 cycles during byte 2.
    begin
      do_reset();
      rsp_ready = 1'b1;
      req0_a = 32'h1234_5678; req0_b = 32'h1111_1111; req0_sub = 1'b0;
      req0_valid = 1'b1;
      #1;
      wait_ready(1'b0);
      for (int k = 1; k <= 8; k++) begin
        step();
        if (k == 1) req0_valid = 1'b0;
        stall = (k >= 3 && k <= 5);
        #1;
        if (k >= 3 && k <= 5) begin
          check("stall_add_a", add_a, 8'h34);
          check("stall_add_b", add_b, 8'h11);
        end
        check("stall_rsp_valid", rsp_valid, (k == 8));
      end
      check("stall_result", rsp_result, 32'h2345_6789);
      check("stall_carry", rsp_carry, 1'b0);
      step();
    end

    // Reset in cycle T+2 aborts the operation; a pending request then runs.
    begin
      rsp_ready = 1'b1;
      req0_a = 32'hAA; req0_b = 32'h55; req0_sub = 1'b0;
      req0_valid = 1'b1;
      #1;
      wait_ready(1'b0);
      step();                                  // T+1
      req0_valid = 1'b0;
      req1_a = 32'h100; req1_b = 32'h1; req1_sub = 1'b1; req1_valid = 1'b1;
      step();                                  // T+2
      reset_n = 1'b0;
      step();                                  // T+3
      check("abort_rsp_valid", rsp_valid, 1'b0);
      check("abort_add_en", add_add_en, 1'b0);
      check("abort_req1_ready", req1_ready, 1'b0);
      reset_n = 1'b1;
      #1;
      check("abort_pending_ready", req1_ready, 1'b1);
      wait_ready(1'b1);
      collect(32'h100, 32'h1, 1'b1, 32'h0000_00FF, 1'b1, 1'b1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
